sequenciador_de_instrucoes: RTL and testbench
=============================================

// Module: sequenciador_de_instrucoes
// PURPOSE
//  Multi-cycle control FSM for the 8-register/ALU datapath: accepts one 16-bit instruction
//  per valid/ready handshake and drives bus-mux select, register enables, A/G enables and ALU op.
//  Sits between instruction source and datapath; replaces free-running step counter with explicit states.
//  Reports completion (done), illegal opcodes (erro) and a retired-instruction count.
// PARAMETERS
//  DATA_WIDTH  16     instruction width; fields below fixed for 16
//  SEL_G       4'd8   mux_select code routing G (ALU result register) to bus
//  SEL_IMM     4'd9   mux_select code routing sign-extended immediate to bus
//  COUNT_WIDTH 16     width of instr_count
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  iin            in   16  instruction: [15:13] opcode, [12:10] rx, [9:7] ry
//  iin_valid      in   1   instruction on iin is valid
//  iin_ready      out  1   sequencer can accept instruction
//  hold           in   1   stall: freeze state and force all enables low
//  mux_select     out  4   bus source: 0-7 = R0-R7, SEL_G, SEL_IMM
//  regs_enable    out  8   one-hot write enable R0-R7
//  a_reg_enable   out  1   load A from bus
//  alu_reg_enable out  1   load G from ALU
//  alu_op_select  out  2   00 add, 01 sub, 10 and, 11 unused
//  done           out  1   one-cycle pulse: instruction retired
//  erro           out  1   one-cycle pulse with done when opcode illegal
//  instr_count    out  COUNT_WIDTH  retired instructions incl. illegal, wraps
// BEHAVIOUR
//  States: IDLE, T1, T2, T3, FIM. Outputs decoded from state + latched IR (Moore, no iin path).
//  Reset: state=IDLE, IR=0, instr_count=0; all enables 0, mux_select=0, alu_op=00, done=erro=0.
//  IDLE: iin_ready=1; iin_valid=1 -> IR<=iin, go T1. iin_ready=0 in every other state.
//  Opcodes: 000 mv rx<-ry; 001 mvi rx<-imm; 010 add; 011 sub; 100 and (rx<-rx op ry); 101-111 illegal.
//  T1 mv : mux=ry, regs_enable[rx]=1 -> FIM.   T1 mvi: mux=SEL_IMM, regs_enable[rx]=1 -> FIM.
//  T1 alu: mux=rx, a_reg_enable=1 -> T2.       T1 illegal: no enables, set erro flag -> FIM.
//  T2 alu: mux=ry, alu_op per opcode, alu_reg_enable=1 -> T3.
//  T3 alu: mux=SEL_G, regs_enable[rx]=1 -> FIM.
//  FIM: done=1 (erro=1 if illegal), instr_count+=1 (wraps 2^COUNT_WIDTH-1 -> 0) -> IDLE.
//  Latency valid-accept to done: mv/mvi/illegal 2 cycles after accept edge; alu 4.
//  Back-to-back: next accept earliest cycle after FIM (one instruction per 3 / 5 cycles).
//  hold=1: state, IR, count frozen; all enables, done, erro forced 0; iin_ready forced 0;
//   on release the frozen state re-issues its outputs in full.
//  rx==ry legal (e.g. add R2,R2 doubles). At most one regs_enable bit high, never with a/alu enable.
//  reset mid-instruction: abort next edge, no further writes, no done pulse, count cleared.
//  iin changes while not IDLE ignored (IR latched only on accept).
// TESTING
//  reset 3 cycles -> iin_ready=1, all enables 0, instr_count=0, done=0.
//  iin=16'h0480 (mv R1,R1? no: 000_001_001) valid 1 cycle -> T1 regs_enable=8'h02 mux=1; done 2 cycles later; count=1.
//  add R0,R1 (iin=16'h4080): T1 mux=0 a_en; T2 mux=1 op=00 g_en; T3 mux=8 regs_enable=8'h01; done; count+1.
//  opcode 111 -> no enables ever high, done=1 and erro=1 same cycle, count+1.
//  sub R3,R4 with hold=1 asserted during T2 for 3 cycles -> enables 0 while held, T2 outputs resume, done delayed 3.
//  reset asserted in T2 of and R5,R6 -> next cycle IDLE, regs_enable never 8'h20, no done; count preset to 16'hFFFF by forcing 65535 retirements (or force) then one more -> wraps to 0.
`

Source files
------------

// File: rtl/sequenciador_de_instrucoes.sv
// -----------------------------------------------------------------------------
// sequenciador_de_instrucoes
//
// Multi-cycle control sequencer for the 8-register / ALU datapath. It accepts
// one 16-bit instruction per valid/ready handshake, latches it into IR and
// steps through IDLE -> T1 [-> T2 -> T3] -> FIM, driving the bus mux select,
// register write enables, A/G load enables and the ALU operation.
//
// All datapath controls are decoded from the current state and the latched IR
// only (Moore style): nothing on iin reaches an output combinationally.
//
// Instruction format: [15:13] opcode, [12:10] rx, [9:7] ry, [6:0] unused here
// (the immediate is sign-extended by the datapath itself).
//   000 mv  rx <- ry        001 mvi rx <- imm
//   010 add rx <- rx + ry   011 sub rx <- rx - ry   100 and rx <- rx & ry
//   101..111 illegal (retired with erro, no writes)
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous active-high reset
//   iin            in   instruction word
//   iin_valid      in   iin holds a valid instruction
//   iin_ready      out  sequencer idle and able to accept
//   hold           in   stall: freeze state/IR/count, force controls low
//   mux_select     out  bus source: 0-7 = R0-R7, SEL_G, SEL_IMM
//   regs_enable    out  one-hot write enable for R0-R7
//   a_reg_enable   out  load A from bus
//   alu_reg_enable out  load G from ALU
//   alu_op_select  out  00 add, 01 sub, 10 and
//   done           out  one-cycle pulse when an instruction retires
//   erro           out  accompanies done when the opcode was illegal
//   instr_count    out  retired instruction count (illegal included), wraps
// -----------------------------------------------------------------------------
module sequenciador_de_instrucoes #(
  parameter int         DATA_WIDTH  = 16,
  parameter logic [3:0] SEL_G       = 4'd8,
  parameter logic [3:0] SEL_IMM     = 4'd9,
  parameter int         COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  iin,
  input  logic                   iin_valid,
  output logic                   iin_ready,
  input  logic                   hold,
  output logic [3:0]             mux_select,
  output logic [7:0]             regs_enable,
  output logic                   a_reg_enable,
  output logic                   alu_reg_enable,
  output logic [1:0]             alu_op_select,
  output logic                   done,
  output logic                   erro,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_FIM  = 3'd4
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  ir_q, ir_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // IR field extraction
  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       unused_imm;

  assign opcode = ir_q[15:13];
  assign rx     = ir_q[12:10];
  assign ry     = ir_q[9:7];
  // Immediate bits are consumed by the datapath, not by the sequencer.
  assign unused_imm = ^ir_q[6:0];

  // Opcode classification
  logic is_mv;
  logic is_mvi;
  logic is_alu;
  logic is_illegal;

  assign is_mv      = (opcode == OP_MV);
  assign is_mvi     = (opcode == OP_MVI);
  assign is_alu     = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND);
  assign is_illegal = !(is_mv || is_mvi || is_alu);

  // One-hot write enable for a register index
  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'd0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Register index as a bus mux code (0-7 select R0-R7)
  function automatic logic [3:0] reg_sel(input logic [2:0] idx);
    return {1'b0, idx};
  endfunction

  // ALU operation for the arithmetic/logic opcodes
  function automatic logic [1:0] alu_op_of(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      OP_ADD:  sel = 2'b00;
      OP_SUB:  sel = 2'b01;
      OP_AND:  sel = 2'b10;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  // Next-state and output decode. hold suppresses every case branch, so the
  // registers keep their value and every control output stays at its default
  // zero; on release the same state decodes its full output set again.
  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    count_d        = count_q;
    iin_ready      = 1'b0;
    mux_select     = 4'd0;
    regs_enable    = 8'd0;
    a_reg_enable   = 1'b0;
    alu_reg_enable = 1'b0;
    alu_op_select  = 2'b00;
    done           = 1'b0;
    erro           = 1'b0;

    if (!hold) begin
      case (state_q)
        S_IDLE: begin
          iin_ready = 1'b1;
          if (iin_valid) begin
            ir_d    = iin;
            state_d = S_T1;
          end
        end

        S_T1: begin
          if (is_mv) begin
            mux_select  = reg_sel(ry);
            regs_enable = reg_onehot(rx);
            state_d     = S_FIM;
          end else if (is_mvi) begin
            mux_select  = SEL_IMM;
            regs_enable = reg_onehot(rx);
            state_d     = S_FIM;
          end else if (is_alu) begin
            mux_select   = reg_sel(rx);
            a_reg_enable = 1'b1;
            state_d      = S_T2;
          end else begin
            // Illegal opcode: no datapath activity, erro is reported in FIM.
            state_d = S_FIM;
          end
        end

        S_T2: begin
          mux_select     = reg_sel(ry);
          alu_op_select  = alu_op_of(opcode);
          alu_reg_enable = 1'b1;
          state_d        = S_T3;
        end

        S_T3: begin
          mux_select  = SEL_G;
          regs_enable = reg_onehot(rx);
          state_d     = S_FIM;
        end

        S_FIM: begin
          done    = 1'b1;
          erro    = is_illegal;
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_sequenciador_de_instrucoes.sv
module tb_sequenciador_de_instrucoes;

  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [15:0]   iin;
  logic          iin_valid;
  logic          iin_ready;
  logic          hold;
  logic [3:0]    mux_select;
  logic [7:0]    regs_enable;
  logic          a_reg_enable;
  logic          alu_reg_enable;
  logic [1:0]    alu_op_select;
  logic          done;
  logic          erro;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] model_count = '0;

  always #5 clock = ~clock;

  sequenciador_de_instrucoes #(.COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .iin(iin), .iin_valid(iin_valid),
    .iin_ready(iin_ready), .hold(hold), .mux_select(mux_select),
    .regs_enable(regs_enable), .a_reg_enable(a_reg_enable),
    .alu_reg_enable(alu_reg_enable), .alu_op_select(alu_op_select),
    .done(done), .erro(erro), .instr_count(instr_count)
  );

  // Observed control outputs packed: mux, regs, a, g, op, done, erro, ready
  logic [18:0] obs;
  assign obs = {mux_select, regs_enable, a_reg_enable, alu_reg_enable,
                alu_op_select, done, erro, iin_ready};

  function automatic logic [18:0] pack(input logic [3:0] mux, input logic [7:0] regs,
                                       input logic a, input logic g, input logic [1:0] op,
                                       input logic dn, input logic er, input logic rdy);
    return {mux, regs, a, g, op, dn, er, rdy};
  endfunction

  // Reference micro-program: number of busy cycles per instruction class
  function automatic int nsteps(input logic [15:0] ins);
    int op;
    op = int'(ins[15:13]);
    return (op >= 2 && op <= 4) ? 4 : 2;
  endfunction

  // Expected outputs in busy cycle k (0 = first cycle after accept)
  function automatic logic [18:0] step_exp(input logic [15:0] ins, input int k);
    int op, rx, ry;
    logic [7:0] wr;
    op = int'(ins[15:13]);
    rx = int'(ins[12:10]);
    ry = int'(ins[9:7]);
    wr = 8'(1 << rx);
    if (op == 0) begin
      if (k == 0) return pack(4'(ry), wr, 0, 0, 2'd0, 0, 0, 0);
      return pack(4'd0, 8'd0, 0, 0, 2'd0, 1, 0, 0);
    end else if (op == 1) begin
      if (k == 0) return pack(4'd9, wr, 0, 0, 2'd0, 0, 0, 0);
      return pack(4'd0, 8'd0, 0, 0, 2'd0, 1, 0, 0);
    end else if (op <= 4) begin
      if (k == 0) return pack(4'(rx), 8'd0, 1, 0, 2'd0, 0, 0, 0);
      if (k == 1) return pack(4'(ry), 8'd0, 0, 1, 2'(op - 2), 0, 0, 0);
      if (k == 2) return pack(4'd8, wr, 0, 0, 2'd0, 0, 0, 0);
      return pack(4'd0, 8'd0, 0, 0, 2'd0, 1, 0, 0);
    end
    if (k == 0) return pack(4'd0, 8'd0, 0, 0, 2'd0, 0, 0, 0);
    return pack(4'd0, 8'd0, 0, 0, 2'd0, 1, 1, 0);
  endfunction

  // Issue one instruction from IDLE (called just after a falling edge) and
  // follow it cycle by cycle; optional hold window before busy step hold_at.
  task automatic run_instr(input logic [15:0] ins, input int hold_at, input int hold_len);
    int n;
    n = nsteps(ins);
    hold = 1'b0; iin = ins; iin_valid = 1'b1;
    #1;
    checks++;
    if (obs !== pack(4'd0, 8'd0, 0, 0, 2'd0, 0, 0, 1)) begin
      errors++;
      $display("FAIL idle_outputs ins=%h: got %h expected %h", ins, obs,
               pack(4'd0, 8'd0, 0, 0, 2'd0, 0, 0, 1));
    end
    checks++;
    if (instr_count !== model_count) begin
      errors++;
      $display("FAIL instr_count ins=%h: got %0d expected %0d", ins, instr_count, model_count);
    end
    @(negedge clock);
    for (int k = 0; k < n; k++) begin
      if (k == hold_at) begin
        for (int h = 0; h < hold_len; h++) begin
          hold = 1'b1; iin = 16'($urandom); iin_valid = 1'($urandom);
          #1;
          checks++;
          if (obs !== 19'd0) begin
            errors++;
            $display("FAIL held_outputs ins=%h step=%0d: got %h expected %h", ins, k, obs, 19'd0);
          end
          @(negedge clock);
        end
      end
      hold = 1'b0; iin = 16'($urandom); iin_valid = 1'($urandom);
      #1;
      checks++;
      if (obs !== step_exp(ins, k)) begin
        errors++;
        $display("FAIL step ins=%h step=%0d: got %h expected %h", ins, k, obs, step_exp(ins, k));
      end
      if (k == n - 1) model_count = model_count + 1'b1;
      @(negedge clock);
    end
    iin_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; iin = 16'hFFFF; iin_valid = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0; iin_valid = 1'b0;
    #1;
    checks++;
    if (obs !== pack(4'd0, 8'd0, 0, 0, 2'd0, 0, 0, 1)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, pack(4'd0, 8'd0, 0, 0, 2'd0, 0, 0, 1));
    end
    checks++;
    if (instr_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", instr_count);
    end
    model_count = '0;
    @(negedge clock);
  endtask

  task automatic test_mv();
    run_instr(16'h0480, -1, 0);
    run_instr(16'h2A00, -1, 0);  // mvi R2
  endtask

  task automatic test_add();
    run_instr(16'h4080, -1, 0);
    run_instr(16'h4900, -1, 0);  // add R2,R2
  endtask

  task automatic test_illegal();
    run_instr(16'hE000, -1, 0);
    run_instr(16'hA5C3, -1, 0);
    run_instr(16'hDF80, -1, 0);
  endtask

  task automatic test_hold();
    // hold while idle blocks acceptance
    hold = 1'b1; iin = 16'h4080; iin_valid = 1'b1;
    #1;
    checks++;
    if (iin_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle_ready: got %b expected 0", iin_ready);
    end
    @(negedge clock);
    iin_valid = 1'b0; hold = 1'b0;
    // sub R3,R4 held for 3 cycles in T2
    run_instr(16'h6E00, 1, 3);
    run_instr(16'h0480, 1, 2);   // hold in FIM delays done
  endtask

  task automatic test_reset_mid();
    hold = 1'b0; iin = 16'h9700; iin_valid = 1'b1;
    @(negedge clock);
    iin_valid = 1'b0;
    #1;
    checks++;
    if (obs !== step_exp(16'h9700, 0)) begin
      errors++;
      $display("FAIL abort_t1: got %h expected %h", obs, step_exp(16'h9700, 0));
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_count = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (obs !== pack(4'd0, 8'd0, 0, 0, 2'd0, 0, 0, 1) || instr_count !== '0) begin
        errors++;
        $display("FAIL abort_idle cycle=%0d: got %h/%0d expected %h/0", c, obs, instr_count,
                 pack(4'd0, 8'd0, 0, 0, 2'd0, 0, 0, 1));
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(1, 3));
      else
        run_instr(16'($urandom), -1, 0);
    end
  endtask

  task automatic test_wrap();
    while (model_count != '1) run_instr(16'($urandom), -1, 0);
    checks++;
    if (instr_count !== '1) begin
      errors++;
      $display("FAIL count_max: got %0d expected %0d", instr_count, {CW{1'b1}});
    end
    run_instr(16'hF000, -1, 0);
    #1;
    checks++;
    if (instr_count !== '0) begin
      errors++;
      $display("FAIL count_wrap: got %0d expected 0", instr_count);
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; iin = '0; iin_valid = 1'b0;
    @(negedge clock);
    test_reset();
    test_mv();
    test_add();
    test_illegal();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
